// File: rtl/wbm_arbiter_core_pkg.sv
// -----------------------------------------------------------------------------
// wbm_arbiter_core_pkg
// Shared definitions for the Wishbone N-to-1 master arbiter:
//   state_e : arbiter FSM encoding (IDLE / BUSY)
//   clog2() : ceil(log2(n)) clamped to a minimum of 1, used for index and
//             counter widths so a single master or TIMEOUT=1 still yields a
//             legal 1-bit vector.
// -----------------------------------------------------------------------------
package wbm_arbiter_core_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage : wbm_arbiter_core_pkg

// File: rtl/wbm_arbiter_core_if.sv
// -----------------------------------------------------------------------------
// wbm_arbiter_core_if
// Bundles both bus faces of the arbiter.
//   Master face : wbm_cyc_i/stb_i/we_i (one bit per master), wbm_adr_i/dat_i
//                 (packed, master k at [k*W +: W]), wbm_mask (1 = enabled),
//                 wbm_dat_o (shared read data), wbm_ack_o/err_o (per-master
//                 one-cycle pulses), wbm_id (current/last granted master).
//   Slave face  : wbs_cyc_o/stb_o/we_o/adr_o/dat_o towards the slave,
//                 wbs_dat_i/ack_i/err_i back from it.
// Modports:
//   arb    : the arbiter itself
//   master : the set of bus masters
//   slave  : the downstream slave / decoder
// -----------------------------------------------------------------------------
interface wbm_arbiter_core_if
  import wbm_arbiter_core_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) ();

  localparam int IW = clog2(NUM_MASTERS);

  // Master side
  logic [NUM_MASTERS-1:0]            wbm_cyc_i;
  logic [NUM_MASTERS-1:0]            wbm_stb_i;
  logic [NUM_MASTERS-1:0]            wbm_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i;
  logic [NUM_MASTERS-1:0]            wbm_mask;
  logic [DATA_WIDTH-1:0]             wbm_dat_o;
  logic [NUM_MASTERS-1:0]            wbm_ack_o;
  logic [NUM_MASTERS-1:0]            wbm_err_o;
  logic [IW-1:0]                     wbm_id;

  // Slave side
  logic                              wbs_cyc_o;
  logic                              wbs_stb_o;
  logic                              wbs_we_o;
  logic [ADDR_WIDTH-1:0]             wbs_adr_o;
  logic [DATA_WIDTH-1:0]             wbs_dat_o;
  logic [DATA_WIDTH-1:0]             wbs_dat_i;
  logic                              wbs_ack_i;
  logic                              wbs_err_i;

  modport arb (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_mask,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_id,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o
  );

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_mask,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_id
  );

  modport slave (
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );

endinterface : wbm_arbiter_core_if

// File: rtl/wbm_prio_enc.sv
// -----------------------------------------------------------------------------
// wbm_prio_enc
// Fixed-priority encoder, highest set index wins.
//   req_i    : candidate vector (pending & mask)
//   onehot_o : one-hot of the winner (all zero if none)
//   idx_o    : binary index of the winner (0 if none)
//   any_o    : at least one candidate
// -----------------------------------------------------------------------------
module wbm_prio_enc
  import wbm_arbiter_core_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    // Ascending scan: a later (higher) hit overwrites earlier ones.
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
        any_o       = 1'b1;
      end
    end
  end

endmodule : wbm_prio_enc

// File: rtl/wbm_arbiter_core.sv
// -----------------------------------------------------------------------------
// wbm_arbiter_core
// Wishbone N-to-1 master arbiter. Each master request (cyc&stb, may be a
// single-cycle pulse) is latched into a per-master pending slot, granted by
// fixed priority (highest index first), forwarded to the single slave bus and
// terminated with a one-cycle ack or err pulse on that master's line.
// Ports:
//   wb_clk_i : bus clock, rising edge
//   wb_rst_i : synchronous reset, active high (aborts any transfer silently)
//   bus      : wbm_arbiter_core_if.arb, master and slave faces
// Timing: request -> pending (1 clk) -> grant/strobe (1 clk) -> slave ack ->
// master ack (1 clk). The FSM returns to IDLE for at least one cycle between
// transfers so a registered-ack slave never sees one strobe twice.
// A transfer waiting TIMEOUT cycles for the slave is terminated with err.
// -----------------------------------------------------------------------------
module wbm_arbiter_core
  import wbm_arbiter_core_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 1024
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wbm_arbiter_core_if.arb  bus
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = clog2(NUM_MASTERS);
  localparam int CW = clog2(TIMEOUT);

  // Capture stage
  logic [N-1:0]  req;        // cyc & stb this cycle
  logic [N-1:0]  accept;     // new request latched into a free, enabled slot
  logic [N-1:0]  reject;     // new request from a masked master
  logic [N-1:0]  drop;       // pending slot of a masked, non-granted master
  logic [N-1:0]  done;       // pending slot retired by a transfer termination
  logic [N-1:0]  pending_q;
  logic          lat_we_q  [N];
  logic [AW-1:0] lat_adr_q [N];
  logic [DW-1:0] lat_dat_q [N];

  // Arbitration
  logic [N-1:0]  cand_oh;
  logic [IW-1:0] cand_idx;
  logic          cand_any;

  // FSM
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start;      // grant issued this cycle
  logic          finish;     // transfer terminates this cycle
  logic          fin_ack;
  logic          fin_err;
  logic          busy;

  // Registered outputs
  logic [N-1:0]  gnt_oh_q;
  logic [IW-1:0] id_q;
  logic          cyc_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic [DW-1:0] rdat_q;
  logic [N-1:0]  ack_q;
  logic [N-1:0]  err_q;

  assign busy = (state_q == ST_BUSY);
  assign done = {N{finish}} & gnt_oh_q;

  // ---------------------------------------------------------------------------
  // Per-master capture
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_cap
    assign req[k]    = bus.wbm_cyc_i[k] & bus.wbm_stb_i[k];
    assign accept[k] = req[k] &  bus.wbm_mask[k] & ~pending_q[k];
    assign reject[k] = req[k] & ~bus.wbm_mask[k] & ~pending_q[k];
    // A master that is masked while waiting is dropped, unless it already owns
    // the bus; an in-flight transfer always runs to completion.
    assign drop[k]   = pending_q[k] & ~bus.wbm_mask[k] & ~(busy & gnt_oh_q[k]);

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        pending_q[k] <= 1'b0;
      end else if (accept[k]) begin
        pending_q[k] <= 1'b1;
      end else if (done[k] || drop[k]) begin
        pending_q[k] <= 1'b0;
      end
    end

    // NOTE: the payload registers carry no reset; they are only read while the
    // matching pending bit is set, and that bit is reset.
    always_ff @(posedge wb_clk_i) begin
      if (accept[k]) begin
        lat_we_q[k]  <= bus.wbm_we_i[k];
        lat_adr_q[k] <= bus.wbm_adr_i[k*AW +: AW];
        lat_dat_q[k] <= bus.wbm_dat_i[k*DW +: DW];
      end
    end
  end : g_cap

  // ---------------------------------------------------------------------------
  // Arbitration: only enabled pending masters compete
  // ---------------------------------------------------------------------------
  wbm_prio_enc #(
    .N (N)
  ) u_prio_enc (
    .req_i    (pending_q & bus.wbm_mask),
    .onehot_o (cand_oh),
    .idx_o    (cand_idx),
    .any_o    (cand_any)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    finish  = 1'b0;
    fin_ack = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.wbs_err_i) begin            // err has precedence over ack
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (bus.wbs_ack_i) begin
          finish  = 1'b1;
          fin_ack = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT BUSY cycles elapsed without a slave termination.
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slave request and master response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gnt_oh_q <= '0;
      id_q     <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      ack_q <= {N{fin_ack}} & gnt_oh_q;
      err_q <= reject | drop | ({N{fin_err}} & gnt_oh_q);
      if (fin_ack) rdat_q <= bus.wbs_dat_i;
      if (start) begin
        gnt_oh_q <= cand_oh;
        id_q     <= cand_idx;
        cyc_q    <= 1'b1;
        we_q     <= lat_we_q[cand_idx];
        adr_q    <= lat_adr_q[cand_idx];
        wdat_q   <= lat_dat_q[cand_idx];
      end else if (finish) begin
        cyc_q    <= 1'b0;
      end
    end
  end

  assign bus.wbs_cyc_o = cyc_q;
  assign bus.wbs_stb_o = cyc_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = wdat_q;
  assign bus.wbm_dat_o = rdat_q;
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_err_o = err_q;
  assign bus.wbm_id    = id_q;

endmodule : wbm_arbiter_core

// File: tb/tb_wbm_arbiter_core.sv
// -----------------------------------------------------------------------------
// tb_wbm_arbiter_core
// Directed bench for wbm_arbiter_core with 4 masters, 16-bit bus, TIMEOUT=16.
// A behavioural registered-ack slave answers each new strobe once; it can be
// made silent or told to error on one address. A monitor counts per-master
// ack/err pulses and the cycle they appeared in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbm_arbiter_core;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbm_arbiter_core_if #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) bus ();

  wbm_arbiter_core #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples 2 ns after each rising edge
  // ---------------------------------------------------------------------------
  int   cyc_n = 0;
  int   ack_cnt [N];
  int   err_cnt [N];
  int   ack_cyc [N];
  int   err_cyc [N];
  int   term_total = 0;
  int   rise_cyc   = 0;
  logic mon_prev   = 1'b0;

  always @(posedge clk) begin
    #2;
    cyc_n++;
    for (int k = 0; k < N; k++) begin
      if (bus.wbm_ack_o[k]) begin ack_cnt[k]++; ack_cyc[k] = cyc_n; term_total++; end
      if (bus.wbm_err_o[k]) begin err_cnt[k]++; err_cyc[k] = cyc_n; term_total++; end
    end
    if (bus.wbs_cyc_o && !mon_prev) rise_cyc = cyc_n;
    mon_prev = bus.wbs_cyc_o;
  end

  // ---------------------------------------------------------------------------
  // Slave model: acts on falling edges, answers each new strobe exactly once
  // ---------------------------------------------------------------------------
  logic          slv_silent  = 1'b0;
  logic          slv_err_en  = 1'b0;
  logic [AW-1:0] slv_err_adr = '0;
  logic          slv_prev    = 1'b0;
  logic [DW-1:0] mem [4];
  logic [DW-1:0] wr_log [$];

  always @(negedge clk) begin
    if (rst) begin
      bus.wbs_ack_i = 1'b0;
      bus.wbs_err_i = 1'b0;
      slv_prev      = 1'b0;
    end else begin
      if (bus.wbs_ack_i || bus.wbs_err_i) begin
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
      end else if (bus.wbs_cyc_o && bus.wbs_stb_o && !slv_prev) begin
        if (bus.wbs_we_o) wr_log.push_back(bus.wbs_dat_o);
        if (!slv_silent) begin
          if (slv_err_en && bus.wbs_adr_o == slv_err_adr) begin
            bus.wbs_err_i = 1'b1;
          end else begin
            bus.wbs_ack_i = 1'b1;
            bus.wbs_dat_i = bus.wbs_we_o ? '0 : mem[bus.wbs_adr_o[1:0]];
          end
        end
      end
      slv_prev = bus.wbs_cyc_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called right after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_req(input logic [N-1:0] who, input logic [N-1:0] we,
                           input logic [N*AW-1:0] adr, input logic [N*DW-1:0] dat);
    bus.wbm_cyc_i = who;
    bus.wbm_stb_i = who;
    bus.wbm_we_i  = we;
    bus.wbm_adr_i = adr;
    bus.wbm_dat_i = dat;
  endtask

  task automatic idle_req();
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_we_i  = '0;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin
      ack_cnt[k] = 0; err_cnt[k] = 0; ack_cyc[k] = 0; err_cyc[k] = 0;
    end
    term_total = 0;
    wr_log.delete();
  endtask

  // Waits (bounded) for n terminations, then a few idle cycles to expose
  // any extra pulse.
  task automatic wait_term(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && term_total < n; i++) @(negedge clk);
    check(tag, term_total >= n, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int t0;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = DW'(3 - i);
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_we_i = '0;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_mask = 4'hF;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = 1'b0; bus.wbs_err_i = 1'b0;

    // --- Reset state ---
    repeat (3) @(negedge clk);
    check("rst_cyc", bus.wbs_cyc_o, 1'b0);
    check("rst_stb", bus.wbs_stb_o, 1'b0);
    check("rst_adr", bus.wbs_adr_o, 16'h0);
    check("rst_ack", bus.wbm_ack_o, 4'h0);
    check("rst_err", bus.wbm_err_o, 4'h0);
    check("rst_dat", bus.wbm_dat_o, 16'h0);
    check("rst_id",  bus.wbm_id,    2'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // --- Write blast: all four pulse together, served 3,2,1,0 ---
    clear_stats();
    t0 = cyc_n;
    drive_req(4'hF, 4'hF, '0, {16'd3, 16'd2, 16'd1, 16'd0});
    @(negedge clk);
    idle_req();
    wait_term("blast_done", 4, 30);
    check("blast_nwr", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("blast_wr%0d", i), wr_log[i], 16'(3 - i));
      check($sformatf("blast_ack%0d", i), ack_cnt[i], 1);
      // 3 cycles to first ack, 2 per transfer thereafter (idle gap).
      check($sformatf("blast_lat%0d", i), ack_cyc[i] - t0, 3 + 2 * (3 - i));
    end
    check("blast_err", err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3], 0);
    check("blast_id", bus.wbm_id, 2'd0);

    // --- Readback: master 0 reads addresses 0..3 ---
    for (int a = 0; a < 4; a++) begin
      clear_stats();
      drive_req(4'h1, 4'h0, {48'h0, 16'(a)}, '0);
      @(negedge clk);
      idle_req();
      wait_term($sformatf("rd_done%0d", a), 1, 20);
      check($sformatf("rd_dat%0d", a), bus.wbm_dat_o, 16'(3 - a));
      check($sformatf("rd_ack%0d", a), ack_cnt[0], 1);
    end

    // --- Mask 1011: master 2 rejected ---
    clear_stats();
    t0 = cyc_n;
    bus.wbm_mask = 4'b1011;
    drive_req(4'hF, 4'hF, '0, {16'd3, 16'd2, 16'd1, 16'd0});
    @(negedge clk);
    idle_req();
    wait_term("mask_done", 4, 30);
    check("mask_err2", err_cnt[2], 1);
    check("mask_err2_lat", err_cyc[2] - t0, 1);
    check("mask_ack2", ack_cnt[2], 0);
    check("mask_acks", ack_cnt[3] + ack_cnt[1] + ack_cnt[0], 3);
    check("mask_nwr", wr_log.size(), 3);
    check("mask_wr0", wr_log[0], 16'd3);
    check("mask_wr1", wr_log[1], 16'd1);
    check("mask_wr2", wr_log[2], 16'd0);
    bus.wbm_mask = 4'hF;

    // --- Slave error on master 1 (address 0x10) ---
    clear_stats();
    t0 = cyc_n;
    slv_err_en  = 1'b1;
    slv_err_adr = 16'h0010;
    drive_req(4'hF, 4'hF, {16'h30, 16'h20, 16'h10, 16'h00}, {16'd3, 16'd2, 16'd1, 16'd0});
    @(negedge clk);
    idle_req();
    wait_term("serr_done", 4, 30);
    check("serr_err1", err_cnt[1], 1);
    check("serr_ack1", ack_cnt[1], 0);
    check("serr_acks", ack_cnt[3] + ack_cnt[2] + ack_cnt[0], 3);
    check("serr_m0_lat", ack_cyc[0] - t0, 9);
    slv_err_en = 1'b0;

    // --- Timeout: slave never answers master 2 ---
    clear_stats();
    slv_silent = 1'b1;
    drive_req(4'h4, 4'h4, '0, {16'd0, 16'h22, 16'd0, 16'd0});
    @(negedge clk);
    idle_req();
    wait_term("to_done", 1, TO + 10);
    check("to_err2", err_cnt[2], 1);
    check("to_ack2", ack_cnt[2], 0);
    check("to_cycles", err_cyc[2] - rise_cyc, TO);
    check("to_cyc_low", bus.wbs_cyc_o, 1'b0);
    slv_silent = 1'b0;

    // --- Reset during BUSY ---
    clear_stats();
    drive_req(4'h1, 4'h0, {48'h0, 16'h1}, '0);
    @(negedge clk);
    idle_req();
    wait_term("pre_rd_done", 1, 20);
    check("pre_rd_dat", bus.wbm_dat_o, 16'd2);
    slv_silent = 1'b1;
    drive_req(4'h8, 4'h0, {16'h2, 48'h0}, '0);
    @(negedge clk);
    idle_req();
    for (int i = 0; i < 10 && !bus.wbs_cyc_o; i++) @(negedge clk);
    check("busy_reached", bus.wbs_cyc_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cyc", bus.wbs_cyc_o, 1'b0);
    check("mid_rst_adr", bus.wbs_adr_o, 16'h0);
    check("mid_rst_dat", bus.wbm_dat_o, 16'h0);
    check("mid_rst_id",  bus.wbm_id,    2'd0);
    check("mid_rst_resp", {bus.wbm_ack_o, bus.wbm_err_o}, 8'h00);
    rst = 1'b0;
    clear_stats();
    slv_silent = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_silent", ack_cnt[3] + err_cnt[3], 0);
    drive_req(4'h2, 4'h2, '0, {16'd0, 16'd0, 16'd5, 16'd0});
    @(negedge clk);
    idle_req();
    wait_term("post_rst_done", 1, 20);
    check("post_rst_ack1", ack_cnt[1], 1);
    check("post_rst_nwr", wr_log.size(), 1);
    check("post_rst_wr", wr_log[0], 16'd5);
    check("post_rst_id", bus.wbm_id, 2'd1);

    // --- Held request ignored while pending; mask cleared while waiting ---
    clear_stats();
    t0 = cyc_n;
    drive_req(4'h9, 4'h9, '0, {16'hA3, 16'd0, 16'd0, 16'hA0});
    @(negedge clk);
    drive_req(4'h8, 4'h8, '0, {16'hA3, 16'd0, 16'd0, 16'hA0});
    @(negedge clk);
    idle_req();
    bus.wbm_mask = 4'b1110;
    wait_term("drop_done", 2, 20);
    check("drop_err0", err_cnt[0], 1);
    check("drop_err0_lat", err_cyc[0] - t0, 3);
    check("drop_ack0", ack_cnt[0], 0);
    check("hold_ack3", ack_cnt[3], 1);
    check("drop_nwr", wr_log.size(), 1);
    bus.wbm_mask = 4'hF;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_wbm_arbiter_core
